branch_hazard_ctrl: RTL and testbench

Control-hazard sequencer for the five-stage RISC-V pipeline. It decodes the instruction in ID for conditional branches, JAL and JALR (opcode[6:2] = 11000, 11011, 11001), then sequences the fetch stage until EX resolves the branch. It drives the PC-hold, IF/ID bubble, flush and PC-select controls. The default policy stalls fetch on every branch; a compile-time option swaps this for predict-not-taken with flush on taken.

---
 rtl/branch_hazard_ctrl_if.sv | 27 ++
 rtl/branch_hazard_ctrl.sv | 123 ++++++++++++
 tb/tb_branch_hazard_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/branch_hazard_ctrl_if.sv
// Handshake bundle between the ID/EX pipeline and branch_hazard_ctrl.
// The pipeline side uses the master modport; the sequencer uses the slave modport.
interface branch_hazard_ctrl_if #(
    parameter int WIDTH_DATA_LENGTH = 32
);
    logic [WIDTH_DATA_LENGTH-1:0] Inst_ID;
    logic                         Inst_Valid;
    logic                         Br_Resolved;
    logic                         Br_Taken;
    logic                         Stall_IF;
    logic                         Bubble_IFID;
    logic                         Flush_IDEX;
    logic                         PC_Sel;
    logic                         Busy;
    logic                         Err;
    logic [15:0]                  Stall_Cnt;

    modport master (
        output Inst_ID, Inst_Valid, Br_Resolved, Br_Taken,
        input  Stall_IF, Bubble_IFID, Flush_IDEX, PC_Sel, Busy, Err, Stall_Cnt
    );

    modport slave (
        input  Inst_ID, Inst_Valid, Br_Resolved, Br_Taken,
        output Stall_IF, Bubble_IFID, Flush_IDEX, PC_Sel, Busy, Err, Stall_Cnt
    );
endinterface

// File: rtl/branch_hazard_ctrl.sv
// Control-hazard sequencer: stalls fetch on branch/JAL/JALR until EX resolves it.
// Define BRANCH_PREDICT_NT_EN for predict-not-taken with flush on taken.
module branch_hazard_ctrl #(
    parameter int WIDTH_DATA_LENGTH = 32,
    parameter int RESOLVE_TIMEOUT   = 15
) (
    input logic                 clk,
    input logic                 rst,
    branch_hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SPEC = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT = 8'(RESOLVE_TIMEOUT);

    state_t      state_q, state_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic        err_q, err_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic [4:0]  opc;
    logic        det;
    logic        stall_if, bubble_ifid, flush_idex, pc_sel;
    logic        unused_inst_bits;

    assign opc = bus.Inst_ID[6:2];
    assign det = bus.Inst_Valid &
                 ((opc == 5'b11000) | (opc == 5'b11011) | (opc == 5'b11001));
    assign unused_inst_bits = ^{bus.Inst_ID[WIDTH_DATA_LENGTH-1:7], bus.Inst_ID[1:0]};

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        err_d       = err_q;
        stall_if    = 1'b0;
        bubble_ifid = 1'b0;
        flush_idex  = 1'b0;
        pc_sel      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (det) begin
`ifdef BRANCH_PREDICT_NT_EN
                    state_d     = SPEC;
`else
                    stall_if    = 1'b1;
                    bubble_ifid = 1'b1;
                    state_d     = WAIT;
`endif
                    wcnt_d      = 8'd0;
                end
            end

            WAIT: begin
                // ID only holds bubbles here, so det is deliberately not examined
                stall_if    = 1'b1;
                bubble_ifid = 1'b1;
                if (bus.Br_Resolved) begin
                    pc_sel  = bus.Br_Taken;
                    state_d = IDLE;
                end else if (wcnt_q == TIMEOUT) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wcnt_d  = wcnt_q + 8'd1;
                end
            end

`ifdef BRANCH_PREDICT_NT_EN
            SPEC: begin
                if (bus.Br_Resolved) begin
                    if (bus.Br_Taken) begin
                        // The wrong-path instruction in ID is flushed, so its det is dropped
                        pc_sel      = 1'b1;
                        bubble_ifid = 1'b1;
                        flush_idex  = 1'b1;
                        state_d     = IDLE;
                    end else if (det) begin
                        state_d     = SPEC;
                        wcnt_d      = 8'd0;
                    end else begin
                        state_d     = IDLE;
                    end
                end else if (wcnt_q == TIMEOUT) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wcnt_d  = wcnt_q + 8'd1;
                end
            end
`endif

            default: state_d = IDLE;
        endcase

        stall_cnt_d = stall_cnt_q + {15'd0, stall_if};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wcnt_q      <= 8'd0;
            err_q       <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.Stall_IF    = stall_if;
    assign bus.Bubble_IFID = bubble_ifid;
    assign bus.Flush_IDEX  = flush_idex;
    assign bus.PC_Sel      = pc_sel;
    assign bus.Busy        = (state_q != IDLE);
    assign bus.Err         = err_q;
    assign bus.Stall_Cnt   = stall_cnt_q;
endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed bench for branch_hazard_ctrl with a cycle-level reference model.
// Build with BRANCH_PREDICT_NT_EN defined to exercise predict-not-taken mode.
module tb_branch_hazard_ctrl;
    localparam int W = 32;
    localparam int T = 15;
    localparam logic [31:0] BEQ  = 32'h0000_0063;
    localparam logic [31:0] BNE  = 32'h0000_1063;
    localparam logic [31:0] JAL  = 32'h0000_006F;
    localparam logic [31:0] JALR = 32'h0000_0067;
    localparam logic [31:0] ADD  = 32'h0000_0033;
`ifdef BRANCH_PREDICT_NT_EN
    localparam bit PNT = 1'b1;
`else
    localparam bit PNT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_hazard_ctrl_if #(.WIDTH_DATA_LENGTH(W)) bus ();

    branch_hazard_ctrl #(
        .WIDTH_DATA_LENGTH(W),
        .RESOLVE_TIMEOUT  (T)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a branch is "pending" from the cycle after detection;
    // the number of cycles it has waited is derived from the detection cycle.
    bit m_pend = 1'b0;
    bit m_err  = 1'b0;
    int m_scnt = 0;
    int m_det  = 0;
    int cyc_no = 0;

    always @(negedge clk) begin
        bit det, e_stall, e_bub, e_flush, e_pc, res, tk;
        int waited;
        if (started) begin
            res = bus.Br_Resolved;
            tk  = bus.Br_Taken;
            det = bus.Inst_Valid &&
                  (bus.Inst_ID[6:2] inside {5'b11000, 5'b11011, 5'b11001});
            waited  = cyc_no - m_det - 1;
            e_stall = 0; e_bub = 0; e_flush = 0; e_pc = 0;
            if (!m_pend) begin
                if (det && !PNT) begin e_stall = 1; e_bub = 1; end
            end else if (!PNT) begin
                e_stall = 1; e_bub = 1; e_pc = res && tk;
            end else if (res && tk) begin
                e_pc = 1; e_bub = 1; e_flush = 1;
            end

            chk("m_stall", int'(bus.Stall_IF), int'(e_stall));
            chk("m_bubble", int'(bus.Bubble_IFID), int'(e_bub));
            chk("m_flush", int'(bus.Flush_IDEX), int'(e_flush));
            chk("m_pcsel", int'(bus.PC_Sel), int'(e_pc));
            chk("m_busy", int'(bus.Busy), int'(m_pend));
            chk("m_err", int'(bus.Err), int'(m_err));
            chk("m_stallcnt", int'(bus.Stall_Cnt), m_scnt);

            if (rst) begin
                m_pend = 0; m_err = 0; m_scnt = 0;
            end else begin
                m_scnt = (m_scnt + int'(e_stall)) % 65536;
                if (!m_pend) begin
                    if (det) begin m_pend = 1; m_det = cyc_no; end
                end else if (res) begin
                    m_pend = PNT && !tk && det;
                    m_det  = cyc_no;
                end else if (waited == T) begin
                    m_err = 1; m_pend = 0;
                end
            end
            cyc_no++;
        end
    end

    // One clock cycle: drive inputs after the edge, return just after the falling edge.
    task automatic cyc(input logic r, input logic v, input logic [31:0] inst,
                       input logic res, input logic tk);
        @(posedge clk); #1;
        rst             = r;
        bus.Inst_Valid  = v;
        bus.Inst_ID     = inst;
        bus.Br_Resolved = res;
        bus.Br_Taken    = tk;
        @(negedge clk); #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, ADD, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.Inst_Valid  = 1'b0;
        bus.Inst_ID     = ADD;
        bus.Br_Resolved = 1'b0;
        bus.Br_Taken    = 1'b0;
        @(posedge clk); #1;
        started = 1'b1;
        cyc(1'b1, 1'b0, ADD, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, ADD, 1'b0, 1'b0);
        idle();
        chk("reset_stall", int'(bus.Stall_IF), 0);
        chk("reset_bubble", int'(bus.Bubble_IFID), 0);
        chk("reset_flush", int'(bus.Flush_IDEX), 0);
        chk("reset_pcsel", int'(bus.PC_Sel), 0);
        chk("reset_busy", int'(bus.Busy), 0);
        chk("reset_err", int'(bus.Err), 0);
        chk("reset_stallcnt", int'(bus.Stall_Cnt), 0);

        cyc(1'b0, 1'b0, ADD, 1'b1, 1'b1);
        chk("spurious_pcsel", int'(bus.PC_Sel), 0);
        chk("spurious_stall", int'(bus.Stall_IF), 0);
        idle();
        chk("spurious_err", int'(bus.Err), 0);
        chk("spurious_busy", int'(bus.Busy), 0);

`ifndef BRANCH_PREDICT_NT_EN
        cyc(1'b0, 1'b1, ADD, 1'b0, 1'b0);
        chk("nonbranch_stall", int'(bus.Stall_IF), 0);
        cyc(1'b0, 1'b1, BEQ, 1'b0, 1'b0);
        chk("beq_stall", int'(bus.Stall_IF), 1);
        chk("beq_bubble", int'(bus.Bubble_IFID), 1);
        chk("beq_pcsel", int'(bus.PC_Sel), 0);
        cyc(1'b0, 1'b0, ADD, 1'b1, 1'b1);
        chk("beq_res_stall", int'(bus.Stall_IF), 1);
        chk("beq_res_pcsel", int'(bus.PC_Sel), 1);
        chk("beq_res_busy", int'(bus.Busy), 1);
        idle();
        chk("beq_after_busy", int'(bus.Busy), 0);
        chk("beq_after_stall", int'(bus.Stall_IF), 0);
        chk("beq_after_pcsel", int'(bus.PC_Sel), 0);
        chk("beq_stallcnt", int'(bus.Stall_Cnt), 2);

        cyc(1'b0, 1'b0, JAL, 1'b0, 1'b0);
        chk("jal_invalid_stall", int'(bus.Stall_IF), 0);
        cyc(1'b0, 1'b1, JAL, 1'b0, 1'b0);
        chk("jal_stall", int'(bus.Stall_IF), 1);
        idle();
        cyc(1'b0, 1'b1, BEQ, 1'b0, 1'b0);
        chk("det_in_wait_busy", int'(bus.Busy), 1);
        cyc(1'b0, 1'b0, ADD, 1'b1, 1'b0);
        chk("jal_res_stall", int'(bus.Stall_IF), 1);
        chk("jal_res_pcsel", int'(bus.PC_Sel), 0);
        idle();
        chk("jal_after_busy", int'(bus.Busy), 0);
        chk("jal_stallcnt", int'(bus.Stall_Cnt), 6);

        cyc(1'b0, 1'b1, JALR, 1'b0, 1'b0);
        for (int i = 0; i < T; i++) idle();
        idle();
        chk("to_last_err", int'(bus.Err), 0);
        chk("to_last_busy", int'(bus.Busy), 1);
        chk("to_last_pcsel", int'(bus.PC_Sel), 0);
        idle();
        chk("to_err", int'(bus.Err), 1);
        chk("to_busy", int'(bus.Busy), 0);
        chk("to_stallcnt", int'(bus.Stall_Cnt), 23);

        cyc(1'b1, 1'b0, ADD, 1'b0, 1'b0);
        idle();
        chk("rst_err_clear", int'(bus.Err), 0);
        chk("rst_stallcnt_clear", int'(bus.Stall_Cnt), 0);
        cyc(1'b0, 1'b1, JALR, 1'b0, 1'b0);
        for (int i = 0; i < T; i++) idle();
        cyc(1'b0, 1'b0, ADD, 1'b1, 1'b1);
        chk("to_res_pcsel", int'(bus.PC_Sel), 1);
        idle();
        chk("to_res_err", int'(bus.Err), 0);
        chk("to_res_busy", int'(bus.Busy), 0);

        cyc(1'b0, 1'b1, BEQ, 1'b0, 1'b0);
        idle();
        cyc(1'b1, 1'b0, ADD, 1'b0, 1'b0);
        chk("midrst_cycle_stall", int'(bus.Stall_IF), 1);
        idle();
        chk("midrst_stall", int'(bus.Stall_IF), 0);
        chk("midrst_bubble", int'(bus.Bubble_IFID), 0);
        chk("midrst_pcsel", int'(bus.PC_Sel), 0);
        chk("midrst_busy", int'(bus.Busy), 0);
        chk("midrst_stallcnt", int'(bus.Stall_Cnt), 0);
`else
        cyc(1'b0, 1'b1, BNE, 1'b0, 1'b0);
        chk("pnt_det_stall", int'(bus.Stall_IF), 0);
        chk("pnt_det_busy", int'(bus.Busy), 0);
        idle();
        chk("pnt_spec_busy", int'(bus.Busy), 1);
        cyc(1'b0, 1'b1, BEQ, 1'b1, 1'b0);
        chk("pnt_nt_pcsel", int'(bus.PC_Sel), 0);
        chk("pnt_nt_flush", int'(bus.Flush_IDEX), 0);
        chk("pnt_nt_bubble", int'(bus.Bubble_IFID), 0);
        idle();
        chk("pnt_b2b_busy", int'(bus.Busy), 1);
        cyc(1'b0, 1'b1, BEQ, 1'b1, 1'b1);
        chk("pnt_tk_pcsel", int'(bus.PC_Sel), 1);
        chk("pnt_tk_bubble", int'(bus.Bubble_IFID), 1);
        chk("pnt_tk_flush", int'(bus.Flush_IDEX), 1);
        chk("pnt_tk_stall", int'(bus.Stall_IF), 0);
        idle();
        chk("pnt_after_busy", int'(bus.Busy), 0);
        chk("pnt_after_flush", int'(bus.Flush_IDEX), 0);
        chk("pnt_stallcnt", int'(bus.Stall_Cnt), 0);
        cyc(1'b0, 1'b1, JAL, 1'b0, 1'b0);
        for (int i = 0; i <= T; i++) idle();
        idle();
        chk("pnt_to_err", int'(bus.Err), 1);
        chk("pnt_to_busy", int'(bus.Busy), 0);
`endif

        idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
